// File: rtl/dmem_mmio_pkg.sv
// Shared register map and status layout for the data-memory / MMIO block.
package dmem_mmio_pkg;

    localparam logic [3:0]  REG_CON    = 4'h0;
    localparam logic [3:0]  REG_CYC_LO = 4'h4;
    localparam logic [3:0]  REG_CYC_HI = 4'h8;
    localparam logic [32:0] MMIO_SPAN  = 33'hC;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the head being popped this edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Byte-addressed data RAM plus a small register window: console TX FIFO and a
// free-running 64-bit cycle counter.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          DEPTH_BYTES = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic [31:0] o_dmem_rdata,
    output logic        o_con_valid,
    output logic [7:0]  o_con_data,
    input  logic        i_con_ready,
    output logic        o_err
);
    localparam int          AW      = $clog2(DEPTH_BYTES);
    localparam logic [32:0] RAM_END = 33'(DEPTH_BYTES);
    localparam logic [32:0] MMIO_LO = {1'b0, MMIO_BASE};
    localparam logic [32:0] MMIO_HI = MMIO_LO + MMIO_SPAN;

    logic [7:0]    mem [DEPTH_BYTES];
    logic [AW-1:0] idx [4];
    region_t       region;
    logic [3:0]    off;
    logic [63:0]   cycle;
    logic          overflow;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          ram_wr;
    logic          mmio_wr;
    logic          push;
    logic          pop;
    logic          cyc_clr;
    logic [31:0]   status;

    always_comb begin
        region = REGION_NONE;
        if ({1'b0, i_dmem_addr} < RAM_END)
            region = REGION_RAM;
        else if (({1'b0, i_dmem_addr} >= MMIO_LO) && ({1'b0, i_dmem_addr} < MMIO_HI))
            region = REGION_MMIO;
    end

    // Window is only 12 bytes, so the low nibble difference is the exact offset.
    assign off = i_dmem_addr[3:0] - MMIO_BASE[3:0];

    always_comb begin
        for (int k = 0; k < 4; k++) idx[k] = i_dmem_addr[AW-1:0] + AW'(k);
    end

    assign ram_wr  = i_dmem_wen && (region == REGION_RAM);
    assign mmio_wr = i_dmem_wen && (region == REGION_MMIO) && !i_rst;
    assign push    = mmio_wr && (off == REG_CON) && i_dmem_mask[0];
    assign cyc_clr = mmio_wr && (off == REG_CYC_LO);
    assign pop     = !fifo_empty && i_con_ready;

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ram_wr && i_dmem_mask[k]) mem[idx[k]] <= i_dmem_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycle    <= '0;
            overflow <= 1'b0;
        end else begin
            cycle <= cyc_clr ? 64'd0 : cycle + 64'd1;
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .DATA_W(8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk  (i_clk),
        .rst  (i_rst),
        .push (push),
        .wdata(i_dmem_wdata[7:0]),
        .pop  (pop),
        .rdata(fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign o_con_valid = !fifo_empty;
    assign o_con_data  = fifo_empty ? 8'h00 : fifo_head;
    assign o_err       = (i_dmem_ren || i_dmem_wen) && (region == REGION_NONE);

    always_comb begin
        status             = '0;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_FULL]  = fifo_full;
        status[STAT_OVF]   = overflow;
    end

    always_comb begin
        o_dmem_rdata = '0;
        if (i_dmem_ren) begin
            if (region == REGION_RAM) begin
                o_dmem_rdata = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
            end else if (region == REGION_MMIO) begin
                case (off)
                    REG_CON:    o_dmem_rdata = status;
                    REG_CYC_LO: o_dmem_rdata = cycle[31:0];
                    REG_CYC_HI: o_dmem_rdata = cycle[63:32];
                    default:    o_dmem_rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: access and console expectations are queued by
// the stimulus and checked by independent monitors.
module tb_dmem_mmio;
    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        err;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t       acc_q[$];
    logic [7:0] con_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    dmem_mmio dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_dmem_addr (addr),
        .i_dmem_ren  (ren),
        .i_dmem_wen  (wen),
        .i_dmem_wdata(wdata),
        .i_dmem_mask (mask),
        .o_dmem_rdata(rdata),
        .o_con_valid (con_valid),
        .o_con_data  (con_data),
        .i_con_ready (con_ready),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Access monitor: every cycle with a request must match the next expectation.
    always @(negedge clk) begin
        if (ren || wen) begin
            if (acc_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_access: got addr 0x%08h expected no access", addr);
            end else begin
                exp_t e;
                e = acc_q.pop_front();
                check({e.name, "_rdata"}, rdata, e.rd);
                check({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
            end
        end
    end

    // Console monitor: every accepted byte must match the next queued byte.
    always @(negedge clk) begin
        if (con_valid && con_ready) begin
            if (con_q.size() == 0) begin
                check("con_unexpected", {24'b0, con_data}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] b;
                b = con_q.pop_front();
                check("con_byte", {24'b0, con_data}, {24'b0, b});
            end
        end
    end

    task automatic access(input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] d, input logic [3:0] m,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
        acc_q.push_back('{name, exp_rd, exp_err});
        addr  = a;
        ren   = r;
        wen   = w;
        wdata = d;
        mask  = m;
        @(posedge clk);
        #1;
        ren   = 1'b0;
        wen   = 1'b0;
        mask  = 4'h0;
        wdata = '0;
        addr  = '0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic accepted);
        if (accepted) con_q.push_back(b);
        access(MB, 1'b0, 1'b1, {24'hFFFFFF, b}, 4'b0001, 32'h0, 1'b0, "push");
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && con_valid; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, {31'b0, con_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        addr      = '0;
        ren       = 1'b0;
        wen       = 1'b0;
        wdata     = '0;
        mask      = 4'h0;
        con_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Writes during reset: RAM takes them, MMIO does not.
        access(32'h20, 1'b0, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "rst_ram_wr");
        access(MB, 1'b0, 1'b1, 32'h99, 4'b0001, 32'h0, 1'b0, "rst_mmio_wr");
        access(MB + 4, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, "rst_cyc_lo");
        rst = 1'b0;
        @(negedge clk);
        check("reset_con_valid", {31'b0, con_valid}, 32'h0);
        check("reset_con_data", {24'b0, con_data}, 32'h0);
        @(posedge clk);
        #1;
        access(32'h20, 1'b1, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "rst_ram_kept");
        access(MB, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, "status_after_reset");

        // Word and byte-lane writes.
        access(32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "sw");
        access(32'h10, 1'b1, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "lw_sw");
        access(32'h10, 1'b0, 1'b1, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, "sb");
        access(32'h10, 1'b1, 1'b0, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, "lw_sb");

        // Wrap-around at the top of RAM.
        access(32'h0, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, "clr_0");
        access(32'h3FC, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0, 1'b0, "clr_3fc");
        access(32'h3FE, 1'b0, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0, "wrap_wr");
        access(32'h3FE, 1'b1, 1'b0, 32'h0, 4'h0, 32'h11223344, 1'b0, "wrap_rd_3fe");
        access(32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h00001122, 1'b0, "wrap_rd_000");
        access(32'h3FC, 1'b1, 1'b0, 32'h0, 4'h0, 32'h33440000, 1'b0, "wrap_rd_3fc");
        access(32'h3FF, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, "idle");
        access(32'h10, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, "idle2");
        acc_q.delete();

        // Empty FIFO, push with ready high: byte shows up only next cycle.
        con_ready = 1'b1;
        con_q.push_back(8'h60);
        acc_q.push_back('{"push_nobypass", 32'h0, 1'b0});
        addr  = MB;
        wen   = 1'b1;
        wdata = 32'h60;
        mask  = 4'b0001;
        @(negedge clk);
        check("no_bypass", {31'b0, con_valid}, 32'h0);
        @(posedge clk);
        #1;
        wen   = 1'b0;
        mask  = 4'h0;
        wdata = '0;
        addr  = '0;
        wait_drain("drain_nobypass");

        // Fill, then push while full and popping: accepted, no overflow.
        con_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'h50 + 8'(i), 1'b1);
        access(MB, 1'b1, 1'b0, 32'h0, 4'h0, 32'h2, 1'b0, "status_full");
        con_ready = 1'b1;
        push_byte(8'h54, 1'b1);
        wait_drain("drain_fullpop");
        access(MB, 1'b1, 1'b0, 32'h0, 4'h0, 32'h1, 1'b0, "status_no_ovf");

        // Overflow: fifth byte dropped, flag sticks.
        con_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'h41 + 8'(i), i < 4);
        access(MB, 1'b1, 1'b0, 32'h0, 4'h0, 32'h6, 1'b0, "status_ovf_full");
        con_ready = 1'b1;
        wait_drain("drain_ovf");
        access(MB, 1'b1, 1'b0, 32'h0, 4'h0, 32'h5, 1'b0, "status_ovf_sticky");

        // Cycle counter clear then count.
        access(MB + 4, 1'b0, 1'b1, 32'h1234, 4'hF, 32'h0, 1'b0, "cyc_clear");
        repeat (10) @(posedge clk);
        #1;
        access(MB + 4, 1'b1, 1'b0, 32'h0, 4'h0, 32'd10, 1'b0, "cyc_lo");
        access(MB + 8, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, "cyc_hi");

        // Unmapped accesses.
        access(32'h4000_0000, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, "unmapped_rd");
        access(32'h4000_0000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "unmapped_wr");
        access(32'h400, 1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, "ram_end_wr");
        access(MB + 12, 1'b1, 1'b1, 32'h77, 4'b0001, 32'h0, 1'b1, "mmio_end_wr");
        access(32'h0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h00001122, 1'b0, "ram_untouched");
        access(MB, 1'b1, 1'b0, 32'h0, 4'h0, 32'h5, 1'b0, "mmio_untouched");
        check("con_idle_after_unmapped", {31'b0, con_valid}, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("acc_queue_empty", acc_q.size(), 32'h0);
        check("con_queue_empty", con_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024, meaning RAM size in bytes (power of two).
REQ-002 SHALL have parameter MMIO_BASE, default 32'h8000_0000, meaning base address of the register window.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning console TX FIFO entries (power of two, >=2).
REQ-004 SHALL have port i_clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port i_rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port i_dmem_addr  input  32  meaning byte address from the hart.
REQ-007 SHALL have port i_dmem_ren  input  1  meaning read request.
REQ-008 SHALL have port i_dmem_wen  input  1  meaning write request.
REQ-009 SHALL have port i_dmem_wdata  input  32  meaning write data, little-endian lanes.
REQ-010 SHALL have port i_dmem_mask  input  4  meaning byte-lane enables; bit k gates wdata[8k+7:8k].
REQ-011 SHALL have port o_dmem_rdata  output  32  meaning read data.
REQ-012 SHALL have port o_con_valid  output  1  meaning console byte available.
REQ-013 SHALL have port o_con_data  output  8  meaning console byte at FIFO head.
REQ-014 SHALL have port i_con_ready  input  1  meaning console sink accepts the byte.
REQ-015 SHALL have port o_err  output  1  meaning access to an unmapped address, combinational.

Function
REQ-016 SHALL decode RAM as addr < DEPTH_BYTES, MMIO as addr in [MMIO_BASE, MMIO_BASE+0xC), everything else unmapped.
REQ-017 SHALL return reads combinationally in the same cycle: rdata = {b[a+3],b[a+2],b[a+1],b[a]}, byte indices modulo DEPTH_BYTES, mask ignored.
REQ-018 SHALL drive o_dmem_rdata = 0 when i_dmem_ren is low or the address is unmapped.
REQ-019 SHALL write RAM at the clock edge, only the lanes with mask set, byte index (addr+k) modulo DEPTH_BYTES.
REQ-020 SHALL map MMIO_BASE+0x0: write with mask[0]=1 pushes wdata[7:0] to TX FIFO; read returns {29'b0, overflow, full, empty}.
REQ-021 SHALL map MMIO_BASE+0x4: read returns cycle[31:0]; any write clears the 64-bit cycle counter.
REQ-022 SHALL map MMIO_BASE+0x8: read returns cycle[63:32]; writes ignored.
REQ-023 SHALL increment the cycle counter by 1 every non-reset cycle, wrapping 2^64-1 -> 0; clear takes precedence over increment (value 0 after the write edge).
REQ-024 SHALL pop the FIFO on edges where o_con_valid & i_con_ready; o_con_valid = !empty; o_con_data = head byte, stable while not popped.
REQ-025 SHALL accept a push when !full, or when full with a pop in the same cycle (count unchanged, order preserved).
REQ-026 SHALL drop a push when full without a concurrent pop and set sticky overflow, cleared only by reset.
REQ-027 SHALL accept push and pop together when empty-then-push: pushed byte appears on o_con_data the following cycle (no bypass).
REQ-028 SHALL assert o_err when (ren|wen) targets an unmapped address; such writes change no state.
REQ-029 SHALL give wen priority over ren for side effects; a read never has side effects.

Reset
REQ-030 SHALL, while i_rst is high, empty the FIFO, clear overflow, and hold the cycle counter at 0.
REQ-031 SHALL produce outputs o_con_valid=0, o_con_data=0, o_err per REQ-028, o_dmem_rdata per REQ-017/018 after reset.
REQ-032 SHALL NOT reset RAM contents; writes during reset are ignored for MMIO and performed for RAM.

Structure
REQ-033 SHALL place register offsets (0x0, 0x4, 0x8) and status bit positions in package dmem_mmio_pkg.
REQ-034 SHALL implement the TX FIFO as sub-module sync_fifo (width 8, depth FIFO_DEPTH, push/pop/full/empty, wrapping pointers with extra MSB).

Verification
REQ-035 SHALL check: sw 0xDEADBEEF to 0x10, mask 1111 -> read 0x10 returns 0xDEADBEEF.
REQ-036 SHALL check: sb lanes mask 0010, wdata 0x0000AA00 to 0x10 -> read returns 0xDEADAAEF.
REQ-037 SHALL check: write to 0x3FE, mask 1111, data 0x11223344 -> bytes 0x3FE=44, 0x3FF=33, 0x000=22, 0x001=11.
REQ-038 SHALL check: i_con_ready=0, push 5 bytes 0x41..0x45 -> status reads 0b110, then ready=1 drains 0x41..0x44 in order.
REQ-039 SHALL check: write 0x8000_0004, then read after 10 idle cycles -> returns 10 (+/- read-cycle offset fixed by REQ-023), HI=0.
REQ-040 SHALL check: read 0x4000_0000 -> o_err=1, rdata 0; write there -> no RAM/MMIO change.
